// File: rtl/mult_div_unit_if.sv
// Handshake and HI/LO access bundle between the datapath and mult_div_unit.
// The master drives requests and MTHI/MTLO writes; the slave reports status and the HI/LO registers.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, in1, in2, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, in1, in2, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Optional macro MDU_EARLY_OUT_EN: multiplies finish once no multiplier bits remain set.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    mult_div_unit_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CW-1:0]      counter;
    logic               is_div;
    logic               zero_div;
    logic               neg_q;
    logic               neg_r;

    // Multiply: acc is the running product, addend the shifted multiplicand, shifter the multiplier.
    // Divide: acc upper half is the remainder, addend low half the divisor, shifter dividend/quotient.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   shifter;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.in1[WIDTH-1];
        b_neg     = signed_op & bus.in2[WIDTH-1];
        a_mag     = a_neg ? -bus.in1 : bus.in1;
        b_mag     = b_neg ? -bus.in2 : bus.in2;
    end

    logic [2*WIDTH-1:0] mul_acc_next;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_final;
    logic [WIDTH-1:0]   quo_final;
    logic               last_step;

    // A negative trial difference means the divisor did not fit: restore by keeping the shifted remainder.
    always_comb begin
        mul_acc_next = shifter[0] ? (acc + addend) : acc;
        mul_product  = neg_q ? -mul_acc_next : mul_acc_next;
        trial        = {1'b0, acc[2*WIDTH-1:WIDTH], shifter[WIDTH-1]}
                     - {2'b00, addend[WIDTH-1:0]};
        if (trial[WIDTH+1]) begin
            rem_next = {acc[2*WIDTH-2:WIDTH], shifter[WIDTH-1]};
            quo_next = {shifter[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {shifter[WIDTH-2:0], 1'b1};
        end
        quo_final = neg_q ? -quo_next : quo_next;
        rem_final = neg_r ? -rem_next : rem_next;
        last_step = zero_div || (counter == LAST);
`ifdef MDU_EARLY_OUT_EN
        if (!is_div && (shifter[WIDTH-1:1] == '0)) begin
            last_step = 1'b1;
        end
`else
`endif
    end

    // A zero divisor still passes through one RUN cycle so its done lands one edge after the start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            counter  <= '0;
            is_div   <= 1'b0;
            zero_div <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            acc      <= '0;
            addend   <= '0;
            shifter  <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (!busy_q) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        busy_q   <= 1'b1;
                        counter  <= '0;
                        is_div   <= bus.op[1];
                        zero_div <= bus.op[1] && (bus.in2 == '0);
                        neg_q    <= a_neg ^ b_neg;
                        if (bus.op[1]) begin
                            acc     <= {((bus.in2 == '0) ? bus.in1 : {WIDTH{1'b0}}), {WIDTH{1'b0}}};
                            addend  <= {{WIDTH{1'b0}}, b_mag};
                            shifter <= a_mag;
                            neg_r   <= a_neg;
                        end else begin
                            acc     <= '0;
                            addend  <= {{WIDTH{1'b0}}, a_mag};
                            shifter <= b_mag;
                            neg_r   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    counter <= counter + CW'(1);
                    if (is_div) begin
                        acc[2*WIDTH-1:WIDTH] <= rem_next;
                        shifter              <= quo_next;
                    end else begin
                        acc     <= mul_acc_next;
                        addend  <= addend << 1;
                        shifter <= shifter >> 1;
                    end
                    if (last_step) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        if (zero_div) begin
                            hi_q  <= acc[2*WIDTH-1:WIDTH];
                            lo_q  <= '1;
                            dbz_q <= 1'b1;
                        end else if (is_div) begin
                            hi_q <= rem_final;
                            lo_q <= quo_final;
                        end else begin
                            hi_q <= mul_product[2*WIDTH-1:WIDTH];
                            lo_q <= mul_product[WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expectations, a monitor checks each done.
// Expected latencies follow the MDU_EARLY_OUT_EN build setting.
module tb_mult_div_unit;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic clock;
    logic reset_n;
    int   cycle;
    int   vectors;
    int   miscompares;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          at;
        string       name;
    } exp_t;

    exp_t sb[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle = cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation, including its edge.
    always @(negedge clock) begin
        if (reset_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, ".hi"},      64'(bus.hi),          64'(e.hi));
                checkOutput({e.name, ".lo"},      64'(bus.lo),          64'(e.lo));
                checkOutput({e.name, ".dbz"},     64'(bus.div_by_zero), 64'(e.dbz));
                checkOutput({e.name, ".busy"},    64'(bus.busy),        64'd0);
                checkOutput({e.name, ".latency"}, 64'(cycle),           64'(e.at));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input logic exp_dbz, input int lat, input string name);
        exp_t e;
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        e.hi   = exp_hi;
        e.lo   = exp_lo;
        e.dbz  = exp_dbz;
        e.at   = cycle + 1 + lat;
        e.name = name;
        sb.push_back(e);
        @(negedge clock);
        bus.start = 1'b0;
        bus.in1   = 32'hDEAD_BEEF;
        bus.in2   = 32'h0BAD_F00D;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s.timeout: got %0d pending, expected 0", name, sb.size());
            sb.delete();
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic writeHiLo(input logic hw, input logic lw, input logic [31:0] data);
        @(negedge clock);
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = data;
        @(negedge clock);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    initial begin
        cycle       = 0;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.in1     = '0;
        bus.in2     = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset.busy", 64'(bus.busy),        64'd0);
        checkOutput("reset.done", 64'(bus.done),        64'd0);
        checkOutput("reset.dbz",  64'(bus.div_by_zero), 64'd0);
        checkOutput("reset.hi",   64'(bus.hi),          64'd0);
        checkOutput("reset.lo",   64'(bus.lo),          64'd0);
        reset_n = 1'b1;

        writeHiLo(1'b1, 1'b1, 32'hCAFE_F00D);
        checkOutput("mthi_mtlo.hi", 64'(bus.hi), 64'hCAFE_F00D);
        checkOutput("mthi_mtlo.lo", 64'(bus.lo), 64'hCAFE_F00D);
        writeHiLo(1'b1, 1'b0, 32'h0000_0011);
        checkOutput("mthi_only.hi", 64'(bus.hi), 64'h11);
        checkOutput("mthi_only.lo", 64'(bus.lo), 64'hCAFE_F00D);

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32, "multu_max");
        checkOutput("multu_max.busy_first", 64'(bus.busy), 64'd1);
        repeat (30) @(negedge clock);
        checkOutput("multu_max.busy_last", 64'(bus.busy), 64'd1);
        drain("multu_max");

        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EO ? 3 : 32, "mult_m3x7");
        drain("mult_m3x7");
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32, "div_m7d2");
        drain("div_m7d2");
        applyStimulus(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32, "divu_100d7");
        drain("divu_100d7");
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32, "div_wrap");
        drain("div_wrap");
        applyStimulus(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, "divu_5d0");
        drain("divu_5d0");
        applyStimulus(2'b11, 32'd6, 32'd3, 32'd0, 32'd2, 1'b0, 32, "divu_6d3");
        drain("divu_6d3");
        applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 32, "mult_minsq");
        drain("mult_minsq");
        applyStimulus(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, EO ? 17 : 32, "multu_2p16sq");
        drain("multu_2p16sq");
        applyStimulus(2'b00, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 1'b0, EO ? 1 : 32, "mult_by_zero");
        drain("mult_by_zero");
        applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 32, "div_7dm2");
        drain("div_7dm2");

        // Second start and an MTHI arrive while busy; both must be ignored.
        applyStimulus(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, EO ? 3 : 32, "multu_3x4");
        repeat (EO ? 1 : 4) @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.in1   = 32'd9;
        bus.in2   = 32'd9;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_00AA;
        @(negedge clock);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        checkOutput("multu_3x4.hi_we_busy", 64'(bus.hi), 64'd1);
        drain("multu_3x4");
        repeat (40) @(negedge clock);
        checkOutput("multu_3x4.idle_after", 64'(bus.busy), 64'd0);

        // Reset in the middle of a divide discards it.
        writeHiLo(1'b1, 1'b0, 32'h0000_0055);
        @(negedge clock);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.in1   = 32'd1000;
        bus.in2   = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("abort.busy", 64'(bus.busy), 64'd0);
        checkOutput("abort.done", 64'(bus.done), 64'd0);
        checkOutput("abort.hi",   64'(bus.hi),   64'd0);
        checkOutput("abort.lo",   64'(bus.lo),   64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        writeHiLo(1'b0, 1'b1, 32'h0000_1234);
        checkOutput("abort.mtlo", 64'(bus.lo), 64'h1234);
        checkOutput("abort.hi_kept", 64'(bus.hi), 64'd0);
        repeat (40) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
